// File: rtl/instr_mem_resp.sv
// instr_mem_resp: instruction-memory responder for the fetch stage.
//   Holds the program image in a single-port, word-addressed RAM. Serves fetch
//   reads with a fixed RD_LAT-cycle latency and accepts program images from
//   the host over a streaming load port.
//
// Optional feature macro: IM_PARITY_EN
//   When defined, each word stores an even-parity bit and every delivered
//   fetch is rechecked; a mismatch sets par_err. When undefined, par_err is 0.
//
// Parameters
//   IMSZLOG2 : word-address width (depth = 2**IMSZLOG2)
//   INSTRW   : instruction word width
//   RD_LAT   : fetch read latency in cycles, legal range 1..4
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   pc_i, iren_i           : fetch address / fetch request
//   instr_o, ins_valid_o   : fetch data / one-cycle data-valid pulse
//   ld_start, ld_base      : begin a program load at ld_base
//   ld_valid, ld_data,
//   ld_last, ld_ready      : load word stream with ready handshake
//   ld_done                : one-cycle pulse when the last word is written
//   prog_valid             : a complete program is resident
//   err_clr                : clears all sticky error flags
//   rd_err, wrap_err,
//   par_err                : sticky error flags
module instr_mem_resp #(
  parameter int unsigned IMSZLOG2 = 10,
  parameter int unsigned INSTRW   = 32,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IMSZLOG2-1:0] pc_i,
  input  logic                iren_i,
  output logic [INSTRW-1:0]   instr_o,
  output logic                ins_valid_o,
  input  logic                ld_start,
  input  logic [IMSZLOG2-1:0] ld_base,
  input  logic                ld_valid,
  input  logic [INSTRW-1:0]   ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  output logic                ld_done,
  output logic                prog_valid,
  input  logic                err_clr,
  output logic                rd_err,
  output logic                wrap_err,
  output logic                par_err
);

  localparam int unsigned DEPTH = 1 << IMSZLOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_wptr_load;
  logic                  w_ld_done_nxt;
  logic                  w_ld_ready_nxt;
  logic                  w_prog_valid_nxt;

  logic [INSTRW-1:0]     r_mem [DEPTH];
  logic [IMSZLOG2-1:0]   r_wptr;
  logic                  r_ld_ready;
  logic                  r_ld_done;
  logic                  r_prog_valid;
  logic                  r_rd_err;
  logic                  r_wrap_err;

  logic [INSTRW-1:0]     r_pdat [RD_LAT];
  logic                  r_pvld [RD_LAT];

  logic                  w_ld_hs;
  logic                  w_rd_fire;
  logic                  w_rd_drop;
  logic                  w_wrap;

  // Load handshake; ld_ready is high exactly while in LOAD.
  assign w_ld_hs   = ld_valid & r_ld_ready;
  // Fetches are served outside LOAD and dropped (with an error) inside it.
  assign w_rd_fire = iren_i & (r_state != S_LOAD);
  assign w_rd_drop = iren_i & (r_state == S_LOAD);
  // Pointer rolls over from all-ones while more words are still to come.
  assign w_wrap    = w_ld_hs & ~ld_last & (r_wptr == '1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and next values for the registered status outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_wptr_load   = 1'b0;
    w_ld_done_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_READY: begin
        if (ld_start) begin
          w_state_nxt = S_LOAD;
          w_wptr_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (w_ld_hs && ld_last) begin
          w_state_nxt   = S_READY;
          w_ld_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_ld_ready_nxt   = (w_state_nxt == S_LOAD);
    w_prog_valid_nxt = (w_state_nxt == S_READY);
  end

  // Load-side registers: write pointer, status outputs, sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_ld_ready   <= 1'b0;
      r_ld_done    <= 1'b0;
      r_prog_valid <= 1'b0;
      r_rd_err     <= 1'b0;
      r_wrap_err   <= 1'b0;
    end else begin
      if (w_wptr_load)  r_wptr <= ld_base;
      else if (w_ld_hs) r_wptr <= r_wptr + IMSZLOG2'(1);
      r_ld_ready   <= w_ld_ready_nxt;
      r_ld_done    <= w_ld_done_nxt;
      r_prog_valid <= w_prog_valid_nxt;
      // A set event in the same cycle as err_clr takes priority.
      if (w_rd_drop)    r_rd_err <= 1'b1;
      else if (err_clr) r_rd_err <= 1'b0;
      if (w_wrap)       r_wrap_err <= 1'b1;
      else if (err_clr) r_wrap_err <= 1'b0;
    end
  end

  // Program storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ld_hs) r_mem[r_wptr] <= ld_data;
  end

  // Read pipeline: stage 0 samples the RAM, later stages shift. Data stages
  // only advance with a valid token so instr_o holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pdat[i] <= '0;
        r_pvld[i] <= 1'b0;
      end
    end else begin
      r_pvld[0] <= w_rd_fire;
      if (w_rd_fire) r_pdat[0] <= r_mem[pc_i];
      for (int i = 1; i < RD_LAT; i++) begin
        r_pvld[i] <= r_pvld[i-1];
        if (r_pvld[i-1]) r_pdat[i] <= r_pdat[i-1];
      end
    end
  end

  assign instr_o     = r_pdat[RD_LAT-1];
  assign ins_valid_o = r_pvld[RD_LAT-1];
  assign ld_ready    = r_ld_ready;
  assign ld_done     = r_ld_done;
  assign prog_valid  = r_prog_valid;
  assign rd_err      = r_rd_err;
  assign wrap_err    = r_wrap_err;

`ifdef IM_PARITY_EN
  logic r_par_mem [DEPTH];
  logic r_ppar    [RD_LAT];
  logic r_par_err;
  logic w_par_bad;

  // Even-parity bit stored alongside each loaded word.
  always_ff @(posedge clk) begin
    if (w_ld_hs) r_par_mem[r_wptr] <= ^ld_data;
  end

  // Parity travels with its word through the read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_ppar[i] <= 1'b0;
    end else begin
      if (w_rd_fire) r_ppar[0] <= r_par_mem[pc_i];
      for (int i = 1; i < RD_LAT; i++) begin
        if (r_pvld[i-1]) r_ppar[i] <= r_ppar[i-1];
      end
    end
  end

  // Recheck on the delivery cycle; data is delivered regardless.
  assign w_par_bad = r_pvld[RD_LAT-1] & ((^r_pdat[RD_LAT-1]) != r_ppar[RD_LAT-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_par_err <= 1'b0;
    else if (w_par_bad) r_par_err <= 1'b1;
    else if (err_clr)   r_par_err <= 1'b0;
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_resp.sv
// Directed testbench for instr_mem_resp (RD_LAT = 2, 1K x 32).
module tb_instr_mem_resp;

  localparam int unsigned IMSZLOG2 = 10;
  localparam int unsigned INSTRW   = 32;
  localparam int unsigned RD_LAT   = 2;

  logic                clk;
  logic                rst_n;
  logic [IMSZLOG2-1:0] pc_i;
  logic                iren_i;
  logic [INSTRW-1:0]   instr_o;
  logic                ins_valid_o;
  logic                ld_start;
  logic [IMSZLOG2-1:0] ld_base;
  logic                ld_valid;
  logic [INSTRW-1:0]   ld_data;
  logic                ld_last;
  logic                ld_ready;
  logic                ld_done;
  logic                prog_valid;
  logic                err_clr;
  logic                rd_err;
  logic                wrap_err;
  logic                par_err;

  int n_vec = 0;
  int n_err = 0;

  instr_mem_resp #(.IMSZLOG2(IMSZLOG2), .INSTRW(INSTRW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .iren_i(iren_i),
    .instr_o(instr_o), .ins_valid_o(ins_valid_o),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_done(ld_done), .prog_valid(prog_valid), .err_clr(err_clr),
    .rd_err(rd_err), .wrap_err(wrap_err), .par_err(par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [IMSZLOG2-1:0] base);
    ld_start = 1'b1;
    ld_base  = base;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_word(input logic [INSTRW-1:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Issue one fetch and watch a bounded window; lat = -1 if nothing came back.
  task automatic fetch(input logic [IMSZLOG2-1:0] a, output logic [INSTRW-1:0] d,
                       output int lat);
    iren_i = 1'b1;
    pc_i   = a;
    lat    = -1;
    d      = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      iren_i = 1'b0;
      if (ins_valid_o === 1'b1 && lat < 0) begin
        lat = c;
        d   = instr_o;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_i = '0; iren_i = 1'b0; ld_start = 1'b0; ld_base = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({instr_o, ins_valid_o, ld_ready, ld_done, prog_valid, rd_err, wrap_err, par_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got instr=%h v=%b rdy=%b done=%b pv=%b rde=%b wre=%b pe=%b want all 0",
               instr_o, ins_valid_o, ld_ready, ld_done, prog_valid, rd_err, wrap_err, par_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    start_load(10'h010);
    n_vec++;
    if (ld_ready !== 1'b1 || prog_valid !== 1'b0) begin
      n_err++;
      $display("FAIL load_enter: got rdy=%b pv=%b want 1 0", ld_ready, prog_valid);
    end
    for (int i = 0; i < 4; i++) begin
      send_word(32'hA0 + 32'(i), i == 3);
      n_vec++;
      if (i < 3 && (ld_done !== 1'b0 || ld_ready !== 1'b1)) begin
        n_err++;
        $display("FAIL load_word%0d: got done=%b rdy=%b want 0 1", i, ld_done, ld_ready);
      end else if (i == 3 && (ld_done !== 1'b1 || prog_valid !== 1'b1 || ld_ready !== 1'b0)) begin
        n_err++;
        $display("FAIL load_last: got done=%b pv=%b rdy=%b want 1 1 0", ld_done, prog_valid, ld_ready);
      end
    end
    tick();
    n_vec++;
    if (ld_done !== 1'b0 || prog_valid !== 1'b1) begin
      n_err++;
      $display("FAIL load_done_pulse: got done=%b pv=%b want 0 1", ld_done, prog_valid);
    end
  endtask

  // Four back-to-back fetches; each returns two cycles after its request.
  task automatic test_back_to_back();
    logic             exp_v;
    logic [INSTRW-1:0] exp_d;
    for (int k = 0; k < 6; k++) begin
      iren_i = (k < 4);
      pc_i   = 10'h010 + 10'(k);
      tick();
      exp_v = (k >= 1 && k <= 4);
      exp_d = (k >= 1 && k <= 4) ? 32'hA0 + 32'(k - 1) : 32'hA3;
      n_vec++;
      if (ins_valid_o !== exp_v || (k >= 1 && instr_o !== exp_d)) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: got v=%b d=%h want v=%b d=%h", k, ins_valid_o, instr_o, exp_v, exp_d);
      end
    end
    iren_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [IMSZLOG2-1:0] addrs [4];
    logic [INSTRW-1:0]   d;
    int                  lat;
    addrs[0] = 10'h3FE; addrs[1] = 10'h3FF; addrs[2] = 10'h000; addrs[3] = 10'h001;
    start_load(10'h3FE);
    send_word(32'hB0, 1'b0);
    n_vec++;
    if (wrap_err !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_early: got wrap_err=%b want 0", wrap_err);
    end
    send_word(32'hB1, 1'b0);
    n_vec++;
    if (wrap_err !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_set: got wrap_err=%b want 1", wrap_err);
    end
    send_word(32'hB2, 1'b0);
    send_word(32'hB3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      fetch(addrs[i], d, lat);
      n_vec++;
      if (d !== 32'hB0 + 32'(i) || lat != int'(RD_LAT)) begin
        n_err++;
        $display("FAIL wrap_read%0d: got d=%h lat=%0d want d=%h lat=%0d", i, d, lat, 32'hB0 + 32'(i), RD_LAT);
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_vec++;
    if (wrap_err !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_clr: got wrap_err=%b want 0", wrap_err);
    end
  endtask

  task automatic test_rd_err();
    iren_i = 1'b1; pc_i = 10'h010;
    tick();
    iren_i = 1'b0;
    start_load(10'h020);
    n_vec++;
    if (ins_valid_o !== 1'b1 || instr_o !== 32'hA0) begin
      n_err++;
      $display("FAIL inflight_read: got v=%b d=%h want 1 000000a0", ins_valid_o, instr_o);
    end
    iren_i = 1'b1; pc_i = 10'h011;
    tick();
    iren_i = 1'b0;
    n_vec++;
    if (rd_err !== 1'b1 || ins_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rd_err_set: got rd_err=%b v=%b want 1 0", rd_err, ins_valid_o);
    end
    tick();
    n_vec++;
    if (ins_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL dropped_read: got v=%b want 0", ins_valid_o);
    end
    send_word(32'hC0, 1'b1);
    n_vec++;
    if (prog_valid !== 1'b1 || rd_err !== 1'b1) begin
      n_err++;
      $display("FAIL rd_err_sticky: got pv=%b rd_err=%b want 1 1", prog_valid, rd_err);
    end
  endtask

  task automatic test_reset_midload();
    logic [INSTRW-1:0] d;
    int                lat;
    start_load(10'h040);
    send_word(32'hD0, 1'b0);
    send_word(32'hD1, 1'b0);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({instr_o, ins_valid_o, ld_ready, ld_done, prog_valid, rd_err, wrap_err, par_err} !== '0) begin
      n_err++;
      $display("FAIL midload_reset: got instr=%h v=%b rdy=%b done=%b pv=%b rde=%b wre=%b pe=%b want all 0",
               instr_o, ins_valid_o, ld_ready, ld_done, prog_valid, rd_err, wrap_err, par_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (ld_ready !== 1'b0 || prog_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got rdy=%b pv=%b want 0 0", ld_ready, prog_valid);
    end
    start_load(10'h050);
    send_word(32'hE0, 1'b1);
    n_vec++;
    if (ld_done !== 1'b1 || prog_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reload_done: got done=%b pv=%b want 1 1", ld_done, prog_valid);
    end
    fetch(10'h050, d, lat);
    n_vec++;
    if (d !== 32'hE0 || lat != int'(RD_LAT)) begin
      n_err++;
      $display("FAIL write_then_read: got d=%h lat=%0d want 000000e0 %0d", d, lat, RD_LAT);
    end
    fetch(10'h041, d, lat);
    n_vec++;
    if (d !== 32'hD1 || lat != int'(RD_LAT)) begin
      n_err++;
      $display("FAIL kept_word: got d=%h lat=%0d want 000000d1 %0d", d, lat, RD_LAT);
    end
  endtask

  task automatic test_parity();
    logic [INSTRW-1:0] d;
    int                lat;
`ifdef IM_PARITY_EN
    dut.r_mem[16] = dut.r_mem[16] ^ 32'h1;
    fetch(10'h010, d, lat);
    n_vec++;
    if (d !== 32'hA1 || lat != int'(RD_LAT) || par_err !== 1'b1) begin
      n_err++;
      $display("FAIL parity_flip: got d=%h lat=%0d pe=%b want 000000a1 %0d 1", d, lat, par_err, RD_LAT);
    end
`else
    fetch(10'h010, d, lat);
    n_vec++;
    if (d !== 32'hA0 || lat != int'(RD_LAT) || par_err !== 1'b0) begin
      n_err++;
      $display("FAIL parity_off: got d=%h lat=%0d pe=%b want 000000a0 %0d 0", d, lat, par_err, RD_LAT);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_wrap();
    test_rd_err();
    test_reset_midload();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
